pixel_pos_ctrl: RTL and testbench

Frame-synchronous position controller for the single-column sprite drawn by the VGA pixel generator. It debounces one push-button and runs a flap/gravity state machine. Once per frame it produces the 9-bit `pixel_pos`, the sprite's bottom edge in lines. The position only changes on the frame tick, so the drawn image never tears mid-frame.

---
 rtl/pixel_pos_ctrl.sv | 160 ++++++++++++++++
 tb/tb_pixel_pos_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/pixel_pos_ctrl.sv
// Sprite position controller: debounces the flap button and advances a
// flap/gravity state machine once per frame so the drawn position never tears.
module pixel_pos_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int START_POS       = 240,
    parameter int TOP_POS         = 50,
    parameter int FLOOR_POS       = 480,
    parameter int JUMP_V          = 8,
    parameter int GRAVITY         = 1,
    parameter int MAX_FALL        = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       btn,
    output logic [8:0] pixel_pos,
    output logic [1:0] state,
    output logic       hit
);

    typedef enum logic [1:0] {
        READY = 2'd0,
        FLY   = 2'd1,
        DEAD  = 2'd2
    } state_t;

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    localparam logic [8:0]         START_P  = 9'(START_POS);
    localparam logic [8:0]         TOP_P    = 9'(TOP_POS);
    localparam logic [8:0]         FLOOR_P  = 9'(FLOOR_POS);
    localparam logic signed [10:0] TOP_N    = 11'(TOP_POS);
    localparam logic signed [10:0] FLOOR_N  = 11'(FLOOR_POS);
    localparam logic signed [7:0]  JUMP_VEL = 8'(-JUMP_V);
    localparam logic signed [8:0]  GRAV_V   = 9'(GRAVITY);
    localparam logic signed [8:0]  MAX_V    = 9'(MAX_FALL);

    logic             sync1_q, sync1_d, sync2_q, sync2_d;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pending_q, pending_d;
    state_t           state_q, state_d;
    logic [8:0]       pos_q, pos_d;
    logic signed [7:0] vel_q, vel_d;
    logic             hit_q, hit_d;

    logic              press_evt, flap;
    logic signed [8:0] v_inc;
    logic signed [7:0] v_new;
    logic signed [10:0] pos_ext, vel_ext, n_pos;

    // Clamp the widened candidate position into the playable band.
    function automatic logic [8:0] sat_pos(input logic signed [10:0] n);
        if (n <= TOP_N)
            return TOP_P;
        else if (n >= FLOOR_N)
            return FLOOR_P;
        else
            return n[8:0];
    endfunction

    always_comb begin
        sync1_d  = btn;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_MAX)
                stable_d = sync2_q;
            else
                cnt_d = cnt_q + CNT_ONE;
        end
        press_evt = stable_d & ~stable_q;
        // A press landing on the tick cycle is consumed by that tick.
        flap      = pending_q | press_evt;
        pending_d = frame_tick ? 1'b0 : (pending_q | press_evt);
    end

    always_comb begin
        v_inc   = $signed({vel_q[7], vel_q}) + GRAV_V;
        v_new   = flap ? JUMP_VEL : ((v_inc > MAX_V) ? MAX_V[7:0] : v_inc[7:0]);
        pos_ext = $signed({2'b00, pos_q});
        vel_ext = $signed({{3{v_new[7]}}, v_new});
        n_pos   = pos_ext + vel_ext;
    end

    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        vel_d   = vel_q;
        hit_d   = 1'b0;
        case (state_q)
            READY: begin
                if (frame_tick && flap) begin
                    vel_d   = JUMP_VEL;
                    pos_d   = sat_pos(n_pos);
                    state_d = FLY;
                end
            end
            FLY: begin
                if (frame_tick) begin
                    pos_d = sat_pos(n_pos);
                    if (n_pos <= TOP_N) begin
                        vel_d = '0;
                    end else if (n_pos >= FLOOR_N) begin
                        vel_d   = '0;
                        state_d = DEAD;
                        hit_d   = 1'b1;
                    end else begin
                        vel_d = v_new;
                    end
                end
            end
            DEAD: begin
                // The restart press does not also flap.
                if (frame_tick && flap) begin
                    pos_d   = START_P;
                    vel_d   = '0;
                    state_d = READY;
                end
            end
            default: begin
                pos_d   = START_P;
                vel_d   = '0;
                state_d = READY;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            stable_q  <= 1'b0;
            cnt_q     <= '0;
            pending_q <= 1'b0;
            state_q   <= READY;
            pos_q     <= START_P;
            vel_q     <= '0;
            hit_q     <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            stable_q  <= stable_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            state_q   <= state_d;
            pos_q     <= pos_d;
            vel_q     <= vel_d;
            hit_q     <= hit_d;
        end
    end

    assign pixel_pos = pos_q;
    assign state     = state_q;
    assign hit       = hit_q;

endmodule

// File: tb/tb_pixel_pos_ctrl.sv
// Directed bench for pixel_pos_ctrl with a short debounce window.
module tb_pixel_pos_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic       frame_tick;
    logic       btn;
    logic [8:0] pixel_pos;
    logic [1:0] state;
    logic       hit;

    int checks   = 0;
    int failures = 0;

    pixel_pos_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .frame_tick (frame_tick),
        .btn        (btn),
        .pixel_pos  (pixel_pos),
        .state      (state),
        .hit        (hit)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit press;
        int exp_pos;
        int exp_state;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Clean press: long enough to be accepted, then released and settled.
    task automatic press();
        btn = 1'b1;
        repeat (8) @(negedge clock);
        btn = 1'b0;
        repeat (8) @(negedge clock);
    endtask

    // Called at a negedge; returns at the negedge where outputs reflect the tick.
    task automatic do_tick();
        @(negedge clock);
        frame_tick = 1'b1;
        @(negedge clock);
        frame_tick = 1'b0;
    endtask

    task automatic check_out(input string name, input int p, input int s, input int h);
        check({name, "_pos"}, int'(pixel_pos), p);
        check({name, "_state"}, int'(state), s);
        check({name, "_hit"}, int'(hit), h);
    endtask

    initial begin
        vecs[0] = '{0, 240, 0};
        vecs[1] = '{0, 240, 0};
        vecs[2] = '{0, 240, 0};
        vecs[3] = '{0, 240, 0};
        vecs[4] = '{0, 240, 0};
        vecs[5] = '{1, 232, 1};
        vecs[6] = '{0, 225, 1};
        vecs[7] = '{0, 219, 1};
        vecs[8] = '{0, 214, 1};

        reset      = 1'b0;
        frame_tick = 1'b0;
        btn        = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        check_out("reset", 240, 0, 0);

        // Idle ticks, first flap, then gravity.
        for (int i = 0; i < 9; i++) begin
            if (vecs[i].press) press();
            do_tick();
            check_out($sformatf("vec%0d", i), vecs[i].exp_pos, vecs[i].exp_state, 0);
        end

        // Repeated flaps climb 8 lines per frame down to 54.
        for (int i = 1; i <= 20; i++) begin
            press();
            do_tick();
            check("climb_pos", int'(pixel_pos), 214 - 8 * i);
        end

        // Top clamp: 54-8 -> 50 with velocity zeroed, then gravity restarts.
        press();
        do_tick();
        check_out("top_clamp", 50, 1, 0);
        do_tick();
        check("top_after1", int'(pixel_pos), 51);
        do_tick();
        check("top_after2", int'(pixel_pos), 53);

        // Free fall: speeds 3..10 then terminal 10.
        begin
            int exp_fall[8] = '{56, 60, 65, 71, 78, 86, 95, 105};
            for (int i = 0; i < 8; i++) begin
                do_tick();
                check("accel_pos", int'(pixel_pos), exp_fall[i]);
            end
        end
        for (int i = 1; i <= 37; i++) begin
            do_tick();
            check("fall_pos", int'(pixel_pos), 105 + 10 * i);
            check("fall_hit", int'(hit), 0);
        end

        // Floor: 475+10 clamps to 480, hit pulses once.
        do_tick();
        check_out("floor", 480, 2, 1);
        @(negedge clock);
        check("floor_hit_drop", int'(hit), 0);
        do_tick();
        check_out("dead_hold1", 480, 2, 0);
        do_tick();
        check_out("dead_hold2", 480, 2, 0);
        press();
        do_tick();
        check_out("restart", 240, 0, 0);
        do_tick();
        check_out("restart_no_flap", 240, 0, 0);

        // Debounce: a 3-cycle glitch is rejected.
        btn = 1'b1;
        repeat (3) @(negedge clock);
        btn = 1'b0;
        repeat (10) @(negedge clock);
        do_tick();
        check_out("glitch", 240, 0, 0);

        // Held 6 cycles: accepted, one flap.
        btn = 1'b1;
        repeat (6) @(negedge clock);
        btn = 1'b0;
        repeat (8) @(negedge clock);
        do_tick();
        check_out("held6", 232, 1, 0);

        // Three presses in one frame collapse into a single flap.
        press();
        press();
        press();
        do_tick();
        check("triple_press", int'(pixel_pos), 224);
        do_tick();
        check("triple_after", int'(pixel_pos), 217);

        // Press event coinciding with a READY tick.
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        check_out("reset2", 240, 0, 0);
        btn = 1'b1;
        repeat (5) @(negedge clock);
        frame_tick = 1'b1;
        @(negedge clock);
        frame_tick = 1'b0;
        check_out("simul_tick", 232, 1, 0);
        btn = 1'b0;
        repeat (8) @(negedge clock);
        do_tick();
        check("simul_pending_clear", int'(pixel_pos), 225);

        // Reset wins over a tick in the same cycle.
        reset      = 1'b0;
        frame_tick = 1'b1;
        @(negedge clock);
        reset      = 1'b1;
        frame_tick = 1'b0;
        check_out("reset_vs_tick", 240, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
